// File: rtl/alu_issue_pkg.sv
// Shared types for the ALU issue stage: FSM state encoding and the buffered descriptor.
package alu_issue_pkg;

  localparam int unsigned ALU_DATA_W  = 8;
  localparam int unsigned ALU_DELAY_W = 3;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ISSUE
  } t_issue_state;

  typedef struct packed {
    logic [3:0]             op;
    logic [1:0]             movi;
    logic [ALU_DATA_W-1:0]  reg_a;
    logic [ALU_DATA_W-1:0]  reg_b;
    logic [ALU_DATA_W-1:0]  mem;
    logic [ALU_DATA_W-1:0]  imm;
    logic [ALU_DELAY_W-1:0] delay;
  } t_alu_desc;

endpackage

// File: rtl/alu_issue_fifo.sv
// Synchronous descriptor FIFO; head is visible combinationally on dout while not empty.
module alu_issue_fifo
  import alu_issue_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  logic      pop,
  input  t_alu_desc din,
  output t_alu_desc dout,
  output logic      full,
  output logic      empty,
  output logic [AW:0] count
);

  t_alu_desc     mem_q [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Issue stage in front of the ALU: buffers descriptors, applies a per-op idle gap,
// and holds the ALU bus until the ALU accepts.
module alu_issue_stage
  import alu_issue_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = ALU_DATA_W,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned DELAY_WIDTH = ALU_DELAY_W
) (
  input  logic                          CLK,
  input  logic                          RST_N,
  input  logic                          IN_VLD,
  output logic                          IN_RDY,
  input  logic [3:0]                    IN_OP,
  input  logic [1:0]                    IN_MOVI,
  input  logic [DATA_WIDTH-1:0]         IN_REG_A,
  input  logic [DATA_WIDTH-1:0]         IN_REG_B,
  input  logic [DATA_WIDTH-1:0]         IN_MEM,
  input  logic [DATA_WIDTH-1:0]         IN_IMM,
  input  logic [DELAY_WIDTH-1:0]        IN_DELAY,
  input  logic                          ALU_RDY,
  output logic                          ACT,
  output logic [3:0]                    OP,
  output logic [1:0]                    MOVI,
  output logic [DATA_WIDTH-1:0]         REG_A,
  output logic [DATA_WIDTH-1:0]         REG_B,
  output logic [DATA_WIDTH-1:0]         MEM,
  output logic [DATA_WIDTH-1:0]         IMM,
  output logic [$clog2(FIFO_DEPTH):0]   FIFO_CNT,
  output logic [15:0]                   ISSUED_CNT
);

  t_issue_state           state, state_nxt;
  logic [DELAY_WIDTH-1:0] dly_cnt, dly_nxt;
  t_alu_desc              in_desc, head;
  logic                   fifo_full, fifo_empty;
  logic                   push, load, hs;

  assign in_desc = '{op: IN_OP, movi: IN_MOVI, reg_a: IN_REG_A, reg_b: IN_REG_B,
                     mem: IN_MEM, imm: IN_IMM, delay: IN_DELAY};
  assign IN_RDY  = !fifo_full;
  assign push    = IN_VLD && IN_RDY;
  assign ACT     = (state == ISSUE);

  alu_issue_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (CLK),
    .rst_n (RST_N),
    .push  (push),
    .pop   (load),
    .din   (in_desc),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (FIFO_CNT)
  );

  always_comb begin
    state_nxt = state;
    dly_nxt   = dly_cnt;
    load      = 1'b0;
    hs        = 1'b0;
    case (state)
      IDLE: load = !fifo_empty;
      WAIT: begin
        dly_nxt = dly_cnt - 1'b1;
        if (dly_cnt <= DELAY_WIDTH'(1)) state_nxt = ISSUE;
      end
      ISSUE: begin
        if (ALU_RDY) begin
          hs = 1'b1;
          if (!fifo_empty) load = 1'b1;
          else             state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // A load from either IDLE or ISSUE picks its next state from the incoming gap.
    if (load) begin
      if (head.delay != '0) begin
        state_nxt = WAIT;
        dly_nxt   = head.delay;
      end else begin
        state_nxt = ISSUE;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= IDLE;
      dly_cnt    <= '0;
      OP         <= '0;
      MOVI       <= '0;
      REG_A      <= '0;
      REG_B      <= '0;
      MEM        <= '0;
      IMM        <= '0;
      ISSUED_CNT <= '0;
    end else begin
      state   <= state_nxt;
      dly_cnt <= dly_nxt;
      if (hs) ISSUED_CNT <= ISSUED_CNT + 16'd1;
      if (load) begin
        OP    <= head.op;
        MOVI  <= head.movi;
        REG_A <= head.reg_a;
        REG_B <= head.reg_b;
        MEM   <= head.mem;
        IMM   <= head.imm;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with hand-computed expectations.
module tb_alu_issue_stage;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       IN_VLD = 1'b0;
  logic       IN_RDY;
  logic [3:0] IN_OP = '0;
  logic [1:0] IN_MOVI = '0;
  logic [7:0] IN_REG_A = '0, IN_REG_B = '0, IN_MEM = '0, IN_IMM = '0;
  logic [2:0] IN_DELAY = '0;
  logic       ALU_RDY = 1'b0;
  logic       ACT;
  logic [3:0] OP;
  logic [1:0] MOVI;
  logic [7:0] REG_A, REG_B, MEM, IMM;
  logic [2:0] FIFO_CNT;
  logic [15:0] ISSUED_CNT;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 CLK = ~CLK;

  alu_issue_stage #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .DELAY_WIDTH(3)) dut (
    .CLK(CLK), .RST_N(RST_N), .IN_VLD(IN_VLD), .IN_RDY(IN_RDY),
    .IN_OP(IN_OP), .IN_MOVI(IN_MOVI), .IN_REG_A(IN_REG_A), .IN_REG_B(IN_REG_B),
    .IN_MEM(IN_MEM), .IN_IMM(IN_IMM), .IN_DELAY(IN_DELAY), .ALU_RDY(ALU_RDY),
    .ACT(ACT), .OP(OP), .MOVI(MOVI), .REG_A(REG_A), .REG_B(REG_B), .MEM(MEM),
    .IMM(IMM), .FIFO_CNT(FIFO_CNT), .ISSUED_CNT(ISSUED_CNT)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // All stimulus is applied 1 time unit after a rising edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [1:0] movi, input logic [7:0] a,
                       input logic [7:0] b, input logic [7:0] m, input logic [7:0] imm,
                       input logic [2:0] d);
    IN_OP = op; IN_MOVI = movi; IN_REG_A = a; IN_REG_B = b;
    IN_MEM = m; IN_IMM = imm; IN_DELAY = d; IN_VLD = 1'b1;
  endtask

  task automatic push_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] imm,
                         input logic [2:0] d);
    drive(op, 2'd2, a, 8'h00, 8'h00, imm, d);
    step();
    IN_VLD = 1'b0;
  endtask

  task automatic gap_test(input logic [2:0] d, input logic [15:0] exp_issued);
    int unsigned gap;
    ALU_RDY = 1'b1;
    push_op(4'h1, 8'h05, 8'h03, d);
    step();
    check_eq("gap_fifo_after_load", FIFO_CNT, 0);
    gap = 0;
    while (!ACT && gap < 20) begin
      gap++;
      step();
    end
    check_eq("gap_len", gap, d);
    step();
    check_eq("gap_act_done", ACT, 0);
    check_eq("gap_issued", ISSUED_CNT, exp_issued);
  endtask

  initial begin
    int unsigned act_cycles;

    // reset state
    step(); step();
    check_eq("rst_act", ACT, 0);
    check_eq("rst_fifo_cnt", FIFO_CNT, 0);
    check_eq("rst_issued", ISSUED_CNT, 0);
    check_eq("rst_op", OP, 0);
    check_eq("rst_in_rdy", IN_RDY, 1);
    RST_N = 1'b1;
    step();

    // single op, no gap
    ALU_RDY = 1'b1;
    push_op(4'h1, 8'h05, 8'h03, 3'd0);
    check_eq("single_cnt_after_push", FIFO_CNT, 1);
    check_eq("single_act_before_load", ACT, 0);
    step();
    check_eq("single_act", ACT, 1);
    check_eq("single_op", OP, 4'h1);
    check_eq("single_reg_a", REG_A, 8'h05);
    check_eq("single_imm", IMM, 8'h03);
    check_eq("single_movi", MOVI, 2'd2);
    check_eq("single_issued_pre", ISSUED_CNT, 0);
    step();
    check_eq("single_act_one_cycle", ACT, 0);
    check_eq("single_issued", ISSUED_CNT, 1);
    check_eq("single_hold_op", OP, 4'h1);

    gap_test(3'd3, 16'd2);
    gap_test(3'd7, 16'd3);

    // backpressure
    ALU_RDY = 1'b0;
    drive(4'h2, 2'd1, 8'h11, 8'h22, 8'h99, 8'h55, 3'd0);
    step();
    IN_VLD = 1'b0;
    step();
    check_eq("bp_act", ACT, 1);
    check_eq("bp_op", OP, 4'h2);
    for (int k = 0; k < 5; k++) begin
      step();
      check_eq("bp_act_held", ACT, 1);
      check_eq("bp_reg_b_stable", REG_B, 8'h22);
      check_eq("bp_mem_stable", MEM, 8'h99);
      check_eq("bp_issued_held", ISSUED_CNT, 3);
    end
    ALU_RDY = 1'b1;
    step();
    check_eq("bp_release_act", ACT, 0);
    check_eq("bp_release_issued", ISSUED_CNT, 4);

    // full FIFO with one op held at the ALU
    ALU_RDY = 1'b0;
    push_op(4'h8, 8'h80, 8'h00, 3'd0);
    push_op(4'h9, 8'h81, 8'h00, 3'd0);
    push_op(4'hA, 8'h82, 8'h00, 3'd0);
    push_op(4'hB, 8'h83, 8'h00, 3'd0);
    push_op(4'hC, 8'h84, 8'h00, 3'd0);
    check_eq("full_cnt", FIFO_CNT, 4);
    check_eq("full_in_rdy", IN_RDY, 0);
    check_eq("full_held_op", OP, 4'h8);
    drive(4'hD, 2'd2, 8'h85, 8'h00, 8'h00, 8'h00, 3'd0);
    step();
    check_eq("full_no_accept", FIFO_CNT, 4);
    check_eq("full_still_op8", OP, 4'h8);
    ALU_RDY = 1'b1;
    step();
    check_eq("full_pop_op", OP, 4'h9);
    check_eq("full_pop_cnt", FIFO_CNT, 3);
    check_eq("full_rdy_back", IN_RDY, 1);
    check_eq("full_issued_a", ISSUED_CNT, 5);
    step();
    IN_VLD = 1'b0;
    check_eq("full_opA", OP, 4'hA);
    check_eq("full_push_pop_cnt", FIFO_CNT, 3);
    for (int k = 0; k < 3; k++) begin
      step();
      check_eq("full_order_op", OP, 32'hB + k);
      check_eq("full_order_reg_a", REG_A, 32'h83 + k);
    end
    step();
    check_eq("full_drain_act", ACT, 0);
    check_eq("full_issued_b", ISSUED_CNT, 10);
    check_eq("full_drain_cnt", FIFO_CNT, 0);

    // asynchronous reset mid-ISSUE
    ALU_RDY = 1'b0;
    push_op(4'h3, 8'h33, 8'h44, 3'd0);
    push_op(4'h4, 8'h34, 8'h45, 3'd0);
    check_eq("mrst_pre_act", ACT, 1);
    check_eq("mrst_pre_cnt", FIFO_CNT, 1);
    #2 RST_N = 1'b0;
    #1;
    check_eq("mrst_act", ACT, 0);
    check_eq("mrst_cnt", FIFO_CNT, 0);
    check_eq("mrst_issued", ISSUED_CNT, 0);
    check_eq("mrst_op", OP, 0);
    check_eq("mrst_reg_a", REG_A, 0);
    check_eq("mrst_imm", IMM, 0);
    #2 RST_N = 1'b1;
    step();
    check_eq("mrst_after_act", ACT, 0);
    check_eq("mrst_after_cnt", FIFO_CNT, 0);

    // long stream across the ISSUED_CNT wrap
    ALU_RDY = 1'b1;
    drive(4'h0, 2'd0, 8'h01, 8'h02, 8'h03, 8'h04, 3'd0);
    act_cycles = 0;
    for (int i = 1; i <= 65537; i++) begin
      IN_OP = 4'(i);
      step();
      if (ACT) act_cycles++;
      if (i == 65537) check_eq("stream_issued_ffff", ISSUED_CNT, 16'hFFFF);
    end
    IN_VLD = 1'b0;
    step();
    if (ACT) act_cycles++;
    check_eq("stream_act_cycles", act_cycles, 65537);
    check_eq("stream_last_op", OP, 4'(65537));
    step();
    check_eq("stream_end_act", ACT, 0);
    check_eq("stream_wrap_issued", ISSUED_CNT, 1);
    check_eq("stream_end_cnt", FIFO_CNT, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
